clock_div_ctrl: RTL and testbench
=================================

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

Interface
REQ-001 SHALL provide clock  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL provide rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide start  input  1  level-sampled run request.
REQ-004 SHALL provide stop  input  1  level-sampled stop request, graceful at period end.
REQ-005 SHALL provide div_val  input  4  requested divide ratio N, legal 2..15.
REQ-006 SHALL provide div_load  input  1  ratio load request, sampled with div_val.
REQ-007 SHALL provide div_ack  output  1  one-cycle pulse: new ratio now active.
REQ-008 SHALL provide tick  output  1  registered one-cycle enable pulse, once per period.
REQ-009 SHALL provide clk_div  output  1  registered divided clock level.
REQ-010 SHALL provide busy  output  1  high when state is not IDLE.
REQ-011 SHALL provide period_cnt  output  8  completed-period count.

Function
REQ-012 SHALL implement states IDLE, RUN and STOPPING.
REQ-013 SHALL hold the internal counter cnt (4 bits) at 0 with tick=0 and clk_div=0 in IDLE.
REQ-014 SHALL transition IDLE->RUN on the edge where start=1 and stop=0; start with stop=1 in IDLE has no effect.
REQ-015 SHALL, in RUN/STOPPING, increment cnt each cycle and wrap to 0 at cnt==ratio_q-1 (terminal count, TC).
REQ-016 SHALL register tick high for exactly the cycle following each TC edge: first tick N cycles after start is sampled, then every N cycles.
REQ-017 SHALL clamp div_val 0 or 1 to 2 on capture.
REQ-018 SHALL apply div_load in IDLE to ratio_q on the sampling edge and pulse div_ack in the next cycle.
REQ-019 SHALL, on div_load in RUN/STOPPING, capture div_val into a pending register, apply it to ratio_q on the next TC edge and pulse div_ack in the cycle after that edge; the current period is never shortened or stretched.
REQ-020 SHALL overwrite a still-pending value on a further div_load; only the last value is applied and only one div_ack is issued.
REQ-021 SHALL apply a pending load on the same TC edge that completes STOPPING->IDLE.
REQ-022 SHALL transition RUN->STOPPING on stop=1; stop has priority over a simultaneous start.
REQ-023 SHALL, in STOPPING, finish the current period, emit its final tick, and enter IDLE on the TC edge.
REQ-024 SHALL return STOPPING->RUN on start=1 with stop=0 without disturbing cnt.
REQ-025 SHALL increment period_cnt on every tick, wrapping 255->0, cleared only by reset.
REQ-026 SHALL drive busy combinationally from state.

Reset
REQ-027 SHALL, on rst_n=0 at a rising edge, force state=IDLE, cnt=0, ratio_q=7, pending cleared, period_cnt=0, tick=0, clk_div=0, div_ack=0.
REQ-028 SHALL, on reset mid-period, abort immediately with no final tick and no div_ack for a pending load.
REQ-029 SHALL ignore start, stop and div_load in any cycle where rst_n=0.

Configuration
REQ-030 SHALL use macro CLK_DIV_DUTY50_EN to select the clk_div waveform.
REQ-031 SHALL, with CLK_DIV_DUTY50_EN defined, drive clk_div high while cnt < (ratio_q+1)/2 (integer) in RUN/STOPPING, else low; N=7 yields 4 high, 3 low.
REQ-032 SHALL, without CLK_DIV_DUTY50_EN, drive clk_div identical to tick.

Verification
REQ-033 SHALL cover: reset, start=1 one cycle, ratio 7 -> tick pulses 7, 14, 21 cycles after start; busy=1; period_cnt 1,2,3.
REQ-034 SHALL cover: div_load div_val=3 in mid-period at ratio 7 -> current period stays 7, div_ack after that TC, subsequent ticks every 3 cycles.
REQ-035 SHALL cover: div_val=0 and 1 loaded in IDLE -> ratio 2, ticks every 2 cycles after start.
REQ-036 SHALL cover: stop at cnt=2, ratio 5 -> one final tick 3 cycles later, then IDLE, busy=0, no further ticks.
REQ-037 SHALL cover: rst_n=0 at cnt=4 with pending load -> all outputs 0 next cycle, ratio_q=7, no div_ack.
REQ-038 SHALL cover: DUTY50 build, ratio 7 -> clk_div 4 high/3 low repeating; non-DUTY50 build -> clk_div equals tick; 256 periods -> period_cnt wraps to 0.

Source files
------------

// File: rtl/clock_div_ctrl.sv
// ---------------------------------------------------------------------------
// clock_div_ctrl
//
// Programmable clock-enable divider with graceful stop and glitch-free
// ratio reload. A 4-bit counter runs from 0 to ratio_q-1 while the block is
// busy. Each terminal count (TC) produces a one-cycle registered tick, and
// each tick advances an 8-bit period counter. A ratio load that arrives
// while the block is running is held in a pending register. It is applied
// only on a TC edge, so a period is never cut short or extended.
//
// Build option:
//   CLK_DIV_DUTY50_EN - if defined, clk_div is a ~50% duty square wave that
//                       is high while cnt < (ratio_q+1)/2. If undefined,
//                       clk_div is identical to tick.
//
// Ports:
//   clock      in   system clock; all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   level-sampled run request (ignored while stop=1)
//   stop       in   level-sampled stop request; stops at the end of the period
//   div_val    in   [3:0] requested ratio N (0 and 1 are clamped to 2)
//   div_load   in   ratio load strobe, sampled together with div_val
//   div_ack    out  one-cycle pulse: the newly loaded ratio is now active
//   tick       out  registered one-cycle pulse, once per period
//   clk_div    out  registered divided clock level
//   busy       out  high whenever the state is not IDLE
//   period_cnt out  [7:0] completed-period count; wraps, cleared only by reset
//   dbg_state  out  [1:0] FSM state (0 IDLE, 1 RUN, 2 STOPPING)
//
// Handshake: div_load is a single-cycle request with no back-pressure. The
// block always accepts it. div_ack fires exactly once, when the last
// requested value takes effect.
// ---------------------------------------------------------------------------
module clock_div_ctrl (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] div_val,
    input  logic       div_load,
    output logic       div_ack,
    output logic       tick,
    output logic       clk_div,
    output logic       busy,
    output logic [7:0] period_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_ratio;
    logic        r_pend_v;
    logic [3:0]  r_pend_val;
    logic        r_tick;
    logic        r_ack;
    logic [7:0]  r_period;

    logic        w_busy;
    logic        w_tc;
    logic [3:0]  w_load_val;
    logic [3:0]  w_next_cnt;
    logic [3:0]  w_next_ratio;
    logic        w_next_pend_v;
    logic [3:0]  w_next_pend_val;
    logic        w_next_ack;

    assign w_busy     = (r_state != S_IDLE);
    assign w_tc       = w_busy && (r_cnt == (r_ratio - 4'd1));
    assign w_load_val = (div_val < 4'd2) ? 4'd2 : div_val;

    // Next-state logic.
    // In STOPPING, a fresh start request wins over the TC edge, so the
    // divider keeps running without a gap.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (start && !stop) w_next_state = S_RUN;
            S_RUN:      if (stop)           w_next_state = S_STOPPING;
            S_STOPPING: begin
                if (start && !stop) w_next_state = S_RUN;
                else if (w_tc)      w_next_state = S_IDLE;
            end
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Datapath next values: counter, ratio and pending-load bookkeeping.
    always_comb begin
        w_next_cnt      = 4'd0;
        w_next_ratio    = r_ratio;
        w_next_pend_v   = r_pend_v;
        w_next_pend_val = r_pend_val;
        w_next_ack      = 1'b0;

        if (w_busy && !w_tc && (w_next_state != S_IDLE))
            w_next_cnt = r_cnt + 4'd1;

        if (!w_busy) begin
            // A load that landed on the final TC edge of STOPPING is left
            // pending. It is flushed here unless a newer load supersedes it.
            if (div_load) begin
                w_next_ratio  = w_load_val;
                w_next_ack    = 1'b1;
                w_next_pend_v = 1'b0;
            end else if (r_pend_v) begin
                w_next_ratio  = r_pend_val;
                w_next_ack    = 1'b1;
                w_next_pend_v = 1'b0;
            end
        end else begin
            if (w_tc && r_pend_v) begin
                w_next_ratio  = r_pend_val;
                w_next_ack    = 1'b1;
                w_next_pend_v = 1'b0;
            end
            // Evaluated after the apply step, so a load on a TC edge is
            // queued for the following period.
            if (div_load) begin
                w_next_pend_v   = 1'b1;
                w_next_pend_val = w_load_val;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_ratio    <= 4'd7;
            r_pend_v   <= 1'b0;
            r_pend_val <= 4'd0;
            r_tick     <= 1'b0;
            r_ack      <= 1'b0;
            r_period   <= 8'd0;
        end else begin
            r_cnt      <= w_next_cnt;
            r_ratio    <= w_next_ratio;
            r_pend_v   <= w_next_pend_v;
            r_pend_val <= w_next_pend_val;
            r_tick     <= w_tc;
            r_ack      <= w_next_ack;
            if (w_tc) r_period <= r_period + 8'd1;
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic       r_clk_div;
    logic [4:0] w_half;

    // The high phase is computed from next-cycle values, so the output
    // stays registered and aligned with cnt.
    assign w_half = ({1'b0, w_next_ratio} + 5'd1) >> 1;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_clk_div <= 1'b0;
        end else begin
            r_clk_div <= (w_next_state != S_IDLE) && ({1'b0, w_next_cnt} < w_half);
        end
    end

    assign clk_div = r_clk_div;
`else
    assign clk_div = r_tick;
`endif

    assign div_ack    = r_ack;
    assign tick       = r_tick;
    assign busy       = w_busy;
    assign period_cnt = r_period;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_div_ctrl
//
// Directed testbench for clock_div_ctrl. Inputs change 1 time unit after a
// rising edge, and outputs are sampled at the same point, so each cyc() call
// observes the result of exactly one clock edge. Expected tick, ack, busy,
// cnt phase and ratio values are worked out by hand for each scenario. The
// expected clk_div is derived from them according to the build option.
// ---------------------------------------------------------------------------
module tb_clock_div_ctrl;

    logic       clock;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] div_val;
    logic       div_load;
    logic       div_ack;
    logic       tick;
    logic       clk_div;
    logic       busy;
    logic [7:0] period_cnt;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    clock_div_ctrl dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .div_val    (div_val),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .tick       (tick),
        .clk_div    (clk_div),
        .busy       (busy),
        .period_cnt (period_cnt),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance one edge, then check the registered outputs. e_cnt and e_ratio
    // describe the counter phase after the edge; they are used only to derive
    // clk_div in the 50% duty build.
    task automatic cyc(input string tag, input int e_tick, input int e_ack,
                       input int e_busy, input int e_cnt, input int e_ratio);
        int e_clk;
        step();
`ifdef CLK_DIV_DUTY50_EN
        e_clk = (e_busy != 0 && e_cnt < (e_ratio + 1) / 2) ? 1 : 0;
`else
        e_clk = e_tick;
        if (e_cnt < 0 || e_ratio < 0) e_clk = -1;
`endif
        check({tag, ".tick"},    int'(tick),    e_tick);
        check({tag, ".ack"},     int'(div_ack), e_ack);
        check({tag, ".busy"},    int'(busy),    e_busy);
        check({tag, ".clk_div"}, int'(clk_div), e_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".tick"},   int'(tick),       0);
        check({tag, ".clkd"},   int'(clk_div),    0);
        check({tag, ".busy"},   int'(busy),       0);
        check({tag, ".ack"},    int'(div_ack),    0);
        check({tag, ".period"}, int'(period_cnt), 0);
        check({tag, ".state"},  int'(dbg_state),  0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; div_load = 1'b0; div_val = 4'd0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Default ratio 7: ticks 7, 14 and 21 cycles after start
        start = 1'b1;
        step();
        start = 1'b0;
        check("r7.busy0",  int'(busy),      1);
        check("r7.state0", int'(dbg_state), 1);
        check("r7.tick0",  int'(tick),      0);
        for (int c = 1; c <= 21; c++) begin
            cyc("r7", (c % 7 == 0) ? 1 : 0, 0, 1, c % 7, 7);
            if (c % 7 == 0) check("r7.period", int'(period_cnt), c / 7);
        end

        // Mid-period load of 3: this period keeps 7, then 3
        cyc("ld3.a", 0, 0, 1, 1, 7);
        cyc("ld3.b", 0, 0, 1, 2, 7);
        div_load = 1'b1; div_val = 4'd3;
        cyc("ld3.c", 0, 0, 1, 3, 7);
        div_load = 1'b0;
        cyc("ld3.d", 0, 0, 1, 4, 7);
        cyc("ld3.e", 0, 0, 1, 5, 7);
        cyc("ld3.f", 0, 0, 1, 6, 7);
        cyc("ld3.tc", 1, 1, 1, 0, 3);
        check("ld3.period", int'(period_cnt), 4);
        for (int k = 1; k <= 6; k++) cyc("r3", (k % 3 == 0) ? 1 : 0, 0, 1, k % 3, 3);
        check("r3.period", int'(period_cnt), 6);

        // Graceful stop at ratio 3
        stop = 1'b1;
        cyc("stp3.a", 0, 0, 1, 1, 3);
        check("stp3.state", int'(dbg_state), 2);
        stop = 1'b0;
        cyc("stp3.b", 0, 0, 1, 2, 3);
        cyc("stp3.tc", 1, 0, 0, 0, 3);
        check("stp3.period", int'(period_cnt), 7);
        cyc("stp3.idle", 0, 0, 0, 0, 3);

        // start together with stop in IDLE has no effect
        start = 1'b1; stop = 1'b1;
        cyc("ss_idle", 0, 0, 0, 0, 3);
        check("ss_idle.state", int'(dbg_state), 0);
        start = 1'b0; stop = 1'b0;

        // IDLE load 5, then stop sampled at cnt=2
        div_load = 1'b1; div_val = 4'd5;
        cyc("ld5", 0, 1, 0, 0, 5);
        div_load = 1'b0;
        cyc("ld5.ackoff", 0, 0, 0, 0, 5);
        start = 1'b1;
        cyc("r5.start", 0, 0, 1, 0, 5);
        start = 1'b0;
        cyc("r5.c1", 0, 0, 1, 1, 5);
        cyc("r5.c2", 0, 0, 1, 2, 5);
        stop = 1'b1;
        cyc("r5.c3", 0, 0, 1, 3, 5);
        stop = 1'b0;
        cyc("r5.c4", 0, 0, 1, 4, 5);
        cyc("r5.final", 1, 0, 0, 0, 5);
        check("r5.period", int'(period_cnt), 8);
        for (int k = 0; k < 4; k++) cyc("r5.quiet", 0, 0, 0, 0, 5);

        // Loads of 0 and 1 clamp to ratio 2
        div_load = 1'b1; div_val = 4'd0;
        cyc("ld0", 0, 1, 0, 0, 2);
        div_val = 4'd1;
        cyc("ld1", 0, 1, 0, 0, 2);
        div_load = 1'b0;
        start = 1'b1;
        cyc("r2.start", 0, 0, 1, 0, 2);
        start = 1'b0;
        for (int c = 1; c <= 6; c++) cyc("r2", (c % 2 == 0) ? 1 : 0, 0, 1, c % 2, 2);
        check("r2.period", int'(period_cnt), 11);

        // stop has priority over a simultaneous start in RUN
        start = 1'b1; stop = 1'b1;
        cyc("r2.ss", 0, 0, 1, 1, 2);
        check("r2.ss.state", int'(dbg_state), 2);
        start = 1'b0; stop = 1'b0;
        cyc("r2.final", 1, 0, 0, 0, 2);
        check("r2.fperiod", int'(period_cnt), 12);

        // Pending overwrite: loads of 9 and then 6 mid-period give one ack, ratio 6
        div_load = 1'b1; div_val = 4'd4;
        cyc("ld4", 0, 1, 0, 0, 4);
        div_load = 1'b0;
        start = 1'b1;
        cyc("r4.start", 0, 0, 1, 0, 4);
        start = 1'b0;
        div_load = 1'b1; div_val = 4'd9;
        cyc("ow.a", 0, 0, 1, 1, 4);
        div_val = 4'd6;
        cyc("ow.b", 0, 0, 1, 2, 4);
        div_load = 1'b0;
        cyc("ow.c", 0, 0, 1, 3, 4);
        cyc("ow.tc", 1, 1, 1, 0, 6);
        check("ow.period", int'(period_cnt), 13);
        for (int c = 1; c <= 6; c++) cyc("r6", (c % 6 == 0) ? 1 : 0, 0, 1, c % 6, 6);
        check("r6.period", int'(period_cnt), 14);

        // Reset at cnt=4 with a load pending; inputs asserted during reset are ignored
        div_load = 1'b1; div_val = 4'd3;
        cyc("rst.a", 0, 0, 1, 1, 6);
        div_load = 1'b0;
        cyc("rst.b", 0, 0, 1, 2, 6);
        cyc("rst.c", 0, 0, 1, 3, 6);
        cyc("rst.d", 0, 0, 1, 4, 6);
        rst_n = 1'b0; start = 1'b1; div_load = 1'b1; div_val = 4'd2;
        step();
        check_reset_outputs("midrst");
        rst_n = 1'b1; start = 1'b0; div_load = 1'b0;
        cyc("midrst.noack", 0, 0, 0, 0, 7);
        start = 1'b1;
        cyc("r7b.start", 0, 0, 1, 0, 7);
        start = 1'b0;
        for (int c = 1; c <= 7; c++) cyc("r7b", (c == 7) ? 1 : 0, 0, 1, c % 7, 7);
        check("r7b.period", int'(period_cnt), 1);

        // 256 periods at ratio 2: period_cnt wraps to 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        div_load = 1'b1; div_val = 4'd2;
        cyc("wrap.ld", 0, 1, 0, 0, 2);
        div_load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 512; c++) begin
            step();
            if (c == 510) check("wrap.255", int'(period_cnt), 255);
            if (c == 511) check("wrap.tick_lo", int'(tick), 0);
            if (c == 512) begin
                check("wrap.zero", int'(period_cnt), 0);
                check("wrap.tick", int'(tick), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
